istack_arbiter: RTL
===================

# istack_arbiter

Two-port arbiter and sequencer for the 24-bit, 256-slot instruction stack. It accepts push/pop requests from the instruction loader (port A) and the evaluator (port B) and grants one at a time. It drives the stack's single-cycle push/pop strobes at the stack's two-cycle operation cadence and tracks occupancy so that overflow and underflow are refused rather than issued. Popped words are returned to the requesting port with a valid pulse.

## Interface
- DATA_W, 24, instruction word width
- DEPTH, 255, usable stack entries (pointer pre-increments, slot 0 unused)
- CNT_W, 8, occupancy counter width; must hold DEPTH
- clk  in  1  clock
- reset_n  in  1  reset, asynchronous, active-low; shared with the stack
- a_req, b_req  in  1  request, held until grant
- a_op, b_op  in  1  0 = push, 1 = pop; stable while req high
- a_wdata, b_wdata  in  DATA_W  push data; stable while req high
- a_gnt, b_gnt  out  1  one-cycle grant pulse (accepted or refused)
- a_err, b_err  out  1  coincident with gnt: op refused (push when full / pop when empty)
- a_rvalid, b_rvalid  out  1  one-cycle pop-data valid for that port
- rdata  out  DATA_W  popped word, valid only with a_rvalid/b_rvalid
- stk_push, stk_pop  out  1  one-cycle strobes to stack
- stk_in  out  DATA_W  push data to stack, held from strobe until next strobe
- stk_out  in  DATA_W  stack read data
- count  out  CNT_W  entries currently on stack
- full, empty  out  1  count == DEPTH, count == 0

## Operation
- FSM states: IDLE, ISSUE, WAIT. Reset: IDLE.
- IDLE: if any req, arbitrate and go to ISSUE; else stay.
- ISSUE (strobe cycle S): registered gnt for winner; if accepted, exactly one of stk_push/stk_pop high, stk_in = winner wdata, count ±1; if refused, err high, no strobe, count unchanged. Always → WAIT.
- WAIT (S+1): stack busy; arbitrate pending reqs; → ISSUE if any, else IDLE.
- Arbitration (RR build): round-robin; after a grant to X, the other port wins a tie. Refused grants also advance the pointer.
- Push refused iff full; pop refused iff empty. Refusal depends on count at arbitration time.
- Pop capture: stk_out sampled at end of S+2, presented on rdata with rvalid of the granting port in S+3. rdata holds until next capture.
- Pending-pop tracking: 2-entry shift of (valid, port) so back-to-back pops return in order to the correct port.
- Requester drops or changes req in S+1 at the earliest. The controller does not sample req in ISSUE.
- Reset mid-operation: FSM → IDLE, count → 0, pending pops discarded, all outputs low. Stack pointer resets concurrently, so no resync is needed.

## Timing
- Reset values: gnt, err, rvalid, stk_push, stk_pop = 0; stk_in, rdata = 0; count = 0; empty = 1; full = 0.
- Req seen in IDLE at cycle t → strobe/gnt at t+1.
- Max throughput: one op per 2 cycles (strobes at S, S+2, …), matching the stack's op0/op1 cadence.
- Pop latency: gnt cycle S → rvalid at S+3.
- Push followed by pop: pop strobe at S+2 returns the just-pushed word.
- count, full and empty are registered; they update the cycle after S.

## Configuration
- ISTACK_ARB_RR_EN defined: round-robin arbitration as above.
- Undefined: fixed priority, port A always wins ties; the RR pointer logic is not compiled in.

## Test plan
- Reset with no reqs → all outputs 0, empty = 1, count = 0; stays in IDLE.
- A pushes 0x000001, 0x000002, then B pops twice → b_rvalid at S+3 of each pop with rdata 0x000002 then 0x000001; count returns to 0.
- A push and B pop held simultaneously from empty, RR build → A granted first (push OK), B next (pop returns A's word); fixed-priority build → same order, and A wins every repeated tie.
- 255 pushes, then a 256th → a_gnt with a_err, no stk_push, count stays 255, full = 1.
- Pop on empty → gnt with err, no stk_pop, no rvalid, count = 0.
- Assert reset_n low during WAIT after a pop strobe → no rvalid ever appears, count = 0; the next push after release issues normally.

Source files
------------

// File: rtl/istack_arbiter.sv
// istack_arbiter
//
// Two-port arbiter and sequencer in front of the 24-bit, 256-slot
// instruction stack. Port A (instruction loader) and port B (evaluator)
// raise push/pop requests. One request is granted at a time, at the
// stack's two-cycle cadence. Occupancy is tracked here so that a push to
// a full stack or a pop from an empty stack is refused instead of issued.
// Popped words come back to the port that asked for them, with a valid
// pulse.
//
// Configuration macro: ISTACK_ARB_RR_EN
//   defined   : round-robin arbitration. After a grant to one port, the
//               other port wins the next tie.
//   undefined : fixed priority. Port A always wins a tie.
//
// Ports
//   clk, reset_n           clock; asynchronous active-low reset
//   a_req/a_op/a_wdata     port A request, op (0 push, 1 pop), push data
//   b_req/b_op/b_wdata     port B request, op, push data
//   a_gnt/b_gnt            one-cycle grant pulse (accepted or refused)
//   a_err/b_err            with gnt: the op was refused
//   a_rvalid/b_rvalid      one-cycle pop-data valid for that port
//   rdata                  popped word, held until the next capture
//   stk_push/stk_pop       one-cycle strobes to the stack
//   stk_in                 push data to the stack, held between strobes
//   stk_out                stack read data
//   count, full, empty     registered occupancy and flags

module istack_arbiter #(
  parameter int DATA_W = 24,
  parameter int DEPTH  = 255,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              a_req,
  input  logic              a_op,
  input  logic [DATA_W-1:0] a_wdata,
  input  logic              b_req,
  input  logic              b_op,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              a_gnt,
  output logic              b_gnt,
  output logic              a_err,
  output logic              b_err,
  output logic              a_rvalid,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic              stk_push,
  output logic              stk_pop,
  output logic [DATA_W-1:0] stk_in,
  input  logic [DATA_W-1:0] stk_out,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              empty
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t state;

`ifdef ISTACK_ARB_RR_EN
  // Set when the most recent grant went to port A. Port B then wins the
  // next tie. It resets low, so port A wins the first tie after reset.
  logic rr_last_a;
`endif

  // Each stage holds one in-flight pop: a valid bit and the requesting
  // port (1 = B). Stage 0 is loaded in S+1 and stage 1 in S+2. Stack data
  // is captured at the end of S+2.
  logic pend0_v, pend0_b, pend1_v, pend1_b;

  logic              any_req;
  logic              pick_b;
  logic              pick_op;
  logic [DATA_W-1:0] pick_data;
  logic              pick_refuse;
  logic [CNT_W-1:0]  count_next;

  // Arbitration and refusal use the registered count. In WAIT the count
  // already reflects the op just issued, so a back-to-back push into the
  // last free slot is refused correctly.
  always_comb begin
    any_req = a_req | b_req;
`ifdef ISTACK_ARB_RR_EN
    pick_b = b_req & (~a_req | rr_last_a);
`else
    pick_b = b_req & ~a_req;
`endif
    pick_op     = pick_b ? b_op : a_op;
    pick_data   = pick_b ? b_wdata : a_wdata;
    pick_refuse = pick_op ? empty : full;

    count_next = count;
    if (stk_push) begin
      count_next = count + CNT_W'(1);
    end else if (stk_pop) begin
      count_next = count - CNT_W'(1);
    end
  end

  // This single sequential block holds the FSM and every registered output.
  // Strobes are only ever high in ISSUE, so the occupancy update and the
  // pop tracking can key directly off the strobe registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      a_gnt    <= 1'b0;
      b_gnt    <= 1'b0;
      a_err    <= 1'b0;
      b_err    <= 1'b0;
      a_rvalid <= 1'b0;
      b_rvalid <= 1'b0;
      rdata    <= '0;
      stk_push <= 1'b0;
      stk_pop  <= 1'b0;
      stk_in   <= '0;
      count    <= '0;
      full     <= 1'b0;
      empty    <= 1'b1;
      pend0_v  <= 1'b0;
      pend0_b  <= 1'b0;
      pend1_v  <= 1'b0;
      pend1_b  <= 1'b0;
`ifdef ISTACK_ARB_RR_EN
      rr_last_a <= 1'b0;
`endif
    end else begin
      a_gnt    <= 1'b0;
      b_gnt    <= 1'b0;
      a_err    <= 1'b0;
      b_err    <= 1'b0;
      stk_push <= 1'b0;
      stk_pop  <= 1'b0;
      a_rvalid <= 1'b0;
      b_rvalid <= 1'b0;

      count <= count_next;
      full  <= (count_next == CNT_W'(DEPTH));
      empty <= (count_next == '0);

      pend0_v <= stk_pop;
      pend0_b <= b_gnt;
      pend1_v <= pend0_v;
      pend1_b <= pend0_b;

      if (pend1_v) begin
        rdata    <= stk_out;
        a_rvalid <= ~pend1_b;
        b_rvalid <= pend1_b;
      end

      case (state)
        IDLE, WAIT: begin
          if (any_req) begin
            state    <= ISSUE;
            a_gnt    <= ~pick_b;
            b_gnt    <= pick_b;
            a_err    <= ~pick_b & pick_refuse;
            b_err    <= pick_b & pick_refuse;
            stk_push <= ~pick_refuse & ~pick_op;
            stk_pop  <= ~pick_refuse & pick_op;
            if (!pick_refuse) begin
              stk_in <= pick_data;
            end
`ifdef ISTACK_ARB_RR_EN
            rr_last_a <= ~pick_b;
`endif
          end else begin
            state <= IDLE;
          end
        end
        ISSUE: begin
          state <= WAIT;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
